// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

    localparam int unsigned BYTE_WIDTH         = 8;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / BYTE_WIDTH;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams instruction words into a byte-wide instruction memory, least significant byte first,
// holding the CPU off via busy_o until the final word has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     word_valid_i,
    output logic                     word_ready_o,
    input  logic [DATA_WIDTH-1:0]    word_i,
    input  logic                     last_i,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [BYTE_WIDTH-1:0]    mem_wdata_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [ADDRESS_WIDTH:0]   byte_count_o
);

    localparam int unsigned BYTES = bytes_per_word(DATA_WIDTH);
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;

    localparam logic [ADDRESS_WIDTH-1:0] BASE       = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [CNT_W:0]           CAPACITY   = (CNT_W + 1)'(1) << ADDRESS_WIDTH;
    localparam logic [CNT_W:0]           WORD_BYTES = (CNT_W + 1)'(BYTES);
    localparam logic [IDX_W-1:0]         LAST_IDX   = IDX_W'(BYTES - 1);

    loader_state_t                       state_q;
    logic [BYTES-1:0][BYTE_WIDTH-1:0]    word_q;
    logic                                last_q;
    logic [IDX_W-1:0]                    idx_q;
    logic [ADDRESS_WIDTH-1:0]            addr_q;
    logic [CNT_W-1:0]                    count_q;
    logic                                has_room;

    // Capacity is judged on bytes written, so a wrapping address never masks an overflow.
    assign has_room = ({1'b0, count_q} + WORD_BYTES) <= CAPACITY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            addr_q  <= BASE;
            count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state_q <= ACCEPT;
                        addr_q  <= BASE;
                        count_q <= '0;
                    end
                end
                ACCEPT: begin
                    if (word_valid_i) begin
                        if (has_room) begin
                            word_q  <= word_i;
                            last_q  <= last_i;
                            idx_q   <= '0;
                            state_q <= WRITE;
                        end else begin
                            state_q <= ERR;
                        end
                    end
                end
                WRITE: begin
                    idx_q   <= idx_q + 1'b1;
                    addr_q  <= addr_q + 1'b1;
                    count_q <= count_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= last_q ? DONE : ACCEPT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        word_ready_o = (state_q == ACCEPT) && has_room;
        mem_we_o     = (state_q == WRITE);
        mem_addr_o   = (state_q == WRITE) ? addr_q : '0;
        mem_wdata_o  = (state_q == WRITE) ? word_q[idx_q] : '0;
        busy_o       = (state_q == ACCEPT) || (state_q == WRITE);
        done_o       = (state_q == DONE);
        err_o        = (state_q == ERR);
        byte_count_o = count_q;
    end

endmodule
